// File: rtl/fp_normalizer_if.sv
// rtl/fp_normalizer_if.sv - handshake bundle between mantissa adder, normalizer and result register
interface fp_normalizer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [32:0] in_sum;
    logic        in_sticky;
    logic        in_bypass;
    logic [31:0] in_bypass_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    modport master (
        output in_valid, in_sign, in_exponent, in_sum, in_sticky, in_bypass, in_bypass_result,
        output out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_sum, in_sticky, in_bypass, in_bypass_result,
        input  out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );
endinterface

// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - FP adder back end: iterative renormalize, round-to-nearest-even, pack
module fp_normalizer #(
    parameter bit FTZ       = 1'b0,
    parameter int MAX_SHIFT = 31
) (
    input  logic            clk,
    input  logic            reset,
    fp_normalizer_if.slave  bus
);
    localparam int CW = $clog2(MAX_SHIFT + 2);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t         state_q;
    logic           sgn_q;
    logic [8:0]     exp_q;
    logic [31:0]    mant_q;
    logic           stk_q;
    logic [CW-1:0]  cnt_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [31:0]    result_q;
    logic           ovf_q;
    logic           uf_q;
    logic           inx_q;

    logic [8:0]     exp_inc;
    logic           rnd_g;
    logic           rnd_r;
    logic           rnd_up;
    logic [24:0]    m24;
    logic [8:0]     exp_rnd;
    logic [31:0]    rnd_result;
    logic           rnd_ovf;
    logic           rnd_uf;
    logic           rnd_inx;

    assign exp_inc = {1'b0, bus.in_exponent} + 9'd1;

    // A carry out of the 24-bit significand bumps the exponent; a subnormal
    // that rounds up into the hidden position becomes the smallest normal.
    always_comb begin
        rnd_g   = mant_q[7];
        rnd_r   = (|mant_q[6:0]) | stk_q;
        rnd_up  = rnd_g & (rnd_r | mant_q[8]);
        m24     = {1'b0, mant_q[31:8]} + {24'd0, rnd_up};
        exp_rnd = exp_q;
        if (m24[24]) begin
            exp_rnd = exp_q + 9'd1;
        end else if (exp_q == 9'd0 && m24[23]) begin
            exp_rnd = 9'd1;
        end
        rnd_inx    = rnd_g | rnd_r;
        rnd_ovf    = 1'b0;
        rnd_uf     = 1'b0;
        rnd_result = {sgn_q, exp_rnd[7:0], (m24[24] ? 23'd0 : m24[22:0])};
        if (exp_rnd >= 9'd255) begin
            rnd_result = {sgn_q, 8'hFF, 23'd0};
            rnd_ovf    = 1'b1;
        end else if (exp_rnd == 9'd0) begin
            rnd_uf = rnd_inx;
            if (FTZ) begin
                rnd_result = {sgn_q, 31'd0};
                rnd_uf     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sgn_q       <= 1'b0;
            exp_q       <= 9'd0;
            mant_q      <= 32'd0;
            stk_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            ovf_q       <= 1'b0;
            uf_q        <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sgn_q      <= bus.in_sign;
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        uf_q       <= 1'b0;
                        inx_q      <= 1'b0;
                        if (bus.in_bypass) begin
                            result_q    <= bus.in_bypass_result;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (bus.in_sum == 33'd0 && !bus.in_sticky) begin
                            result_q    <= 32'd0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (bus.in_sum[32]) begin
                            mant_q <= bus.in_sum[32:1];
                            stk_q  <= bus.in_sticky | bus.in_sum[0];
                            exp_q  <= exp_inc;
                            if (exp_inc >= 9'd255) begin
                                result_q    <= {bus.in_sign, 8'hFF, 23'd0};
                                ovf_q       <= 1'b1;
                                inx_q       <= 1'b1;
                                out_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                state_q <= S_NORM;
                            end
                        end else begin
                            mant_q  <= bus.in_sum[31:0];
                            stk_q   <= bus.in_sticky;
                            exp_q   <= {1'b0, bus.in_exponent};
                            state_q <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    // Stopping at exponent 1 keeps the 9-bit exponent from wrapping.
                    if (mant_q[31]) begin
                        state_q <= S_ROUND;
                    end else if (exp_q <= 9'd1) begin
                        exp_q   <= 9'd0;
                        state_q <= S_ROUND;
                    end else if (cnt_q == CW'(MAX_SHIFT)) begin
                        state_q <= S_ROUND;
                    end else begin
                        mant_q <= {mant_q[30:0], 1'b0};
                        exp_q  <= exp_q - 9'd1;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                S_ROUND: begin
                    result_q    <= rnd_result;
                    ovf_q       <= rnd_ovf;
                    uf_q        <= rnd_uf;
                    inx_q       <= rnd_inx;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = result_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = uf_q;
    assign bus.out_inexact   = inx_q;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - vector table, random model comparison and handshake corners for fp_normalizer
module tb_fp_normalizer;
    localparam int MAX_SHIFT = 31;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fp_normalizer_if b0();
    fp_normalizer_if b1();

    assign b1.in_valid         = b0.in_valid;
    assign b1.in_sign          = b0.in_sign;
    assign b1.in_exponent      = b0.in_exponent;
    assign b1.in_sum           = b0.in_sum;
    assign b1.in_sticky        = b0.in_sticky;
    assign b1.in_bypass        = b0.in_bypass;
    assign b1.in_bypass_result = b0.in_bypass_result;
    assign b1.out_ready        = b0.out_ready;

    fp_normalizer #(.FTZ(1'b0), .MAX_SHIFT(MAX_SHIFT)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    fp_normalizer #(.FTZ(1'b1), .MAX_SHIFT(MAX_SHIFT)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    typedef struct {
        logic        sign;
        logic [7:0]  ex;
        logic [32:0] sum;
        logic        sticky;
        logic        bypass;
        logic [31:0] bres;
        logic [31:0] res0;
        logic [31:0] res1;
        logic        ovf;
        logic        uf0;
        logic        uf1;
        logic        inx;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sign, input logic [7:0] ex, input logic [32:0] sum,
                                input logic st, input logic byp, input logic [31:0] bres,
                                input logic [31:0] res0, input logic [31:0] res1, input logic ovf,
                                input logic uf0, input logic uf1, input logic inx, input int lat);
        vec_t v;
        v.sign = sign; v.ex = ex; v.sum = sum; v.sticky = st; v.bypass = byp; v.bres = bres;
        v.res0 = res0; v.res1 = res1; v.ovf = ovf; v.uf0 = uf0; v.uf1 = uf1; v.inx = inx; v.lat = lat;
        return v;
    endfunction

    // Value-level reference: leading-one search, compare the discarded part against one half.
    function automatic vec_t model(input logic sign, input logic [7:0] ex, input logic [32:0] sum,
                                   input logic st, input logic byp, input logic [31:0] bres);
        vec_t        v;
        logic [63:0] m;
        logic [63:0] keep;
        int          e, msb, need, s, rem;
        logic        stk, up;
        v = mk(sign, ex, sum, st, byp, bres, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        if (byp) begin
            v.res0 = bres; v.res1 = bres;
            return v;
        end
        if (sum == 33'd0 && !st) return v;
        e = int'(ex); m = 64'(sum); stk = st;
        if (sum[32]) begin
            stk = st | sum[0];
            m   = m >> 1;
            e   = e + 1;
            if (e >= 255) begin
                v.res0 = {sign, 8'hFF, 23'd0}; v.res1 = v.res0; v.ovf = 1'b1; v.inx = 1'b1;
                return v;
            end
        end
        msb = -1;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        need = 31 - msb;
        s = need;
        if (e - 1 < s) s = e - 1;
        if (MAX_SHIFT < s) s = MAX_SHIFT;
        m = (m << s) & 64'hFFFF_FFFF;
        if (s == need) e = e - s;
        else if (s == e - 1) e = 0;
        else e = e - s;
        keep = m >> 8;
        rem  = int'(m & 64'hFF);
        up   = (rem > 128) || (rem == 128 && stk) || (rem == 128 && !stk && keep[0]);
        keep = keep + 64'(up);
        v.inx = (rem != 0) || stk;
        if (keep == 64'h100_0000) begin
            keep = 64'h80_0000;
            e    = e + 1;
        end else if (e == 0 && keep >= 64'h80_0000) begin
            e = 1;
        end
        v.lat = 3 + s;
        if (e >= 255) begin
            v.res0 = {sign, 8'hFF, 23'd0}; v.res1 = v.res0; v.ovf = 1'b1;
        end else begin
            v.res0 = {sign, 8'(e), keep[22:0]};
            v.res1 = v.res0;
            if (e == 0) begin
                v.uf0  = v.inx;
                v.uf1  = 1'b1;
                v.res1 = {sign, 31'd0};
            end
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int hold, input string tag);
        int n;
        @(negedge clk);
        chk({tag, " in_ready idle"}, 64'(b0.in_ready), 64'd1);
        b0.in_valid         = 1'b1;
        b0.in_sign          = v.sign;
        b0.in_exponent      = v.ex;
        b0.in_sum           = v.sum;
        b0.in_sticky        = v.sticky;
        b0.in_bypass        = v.bypass;
        b0.in_bypass_result = v.bres;
        b0.out_ready        = (hold == 0);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            if (n == 0) begin
                b0.in_valid = 1'b0;
                chk({tag, " in_ready busy"}, 64'(b0.in_ready), 64'd0);
            end
            n++;
        end while (!b0.out_valid && n < 200);
        chk({tag, " latency"}, 64'(n), 64'(v.lat));
        chk({tag, " ftz1 valid"}, 64'(b1.out_valid), 64'd1);
        chk({tag, " result"}, 64'(b0.out_result), 64'(v.res0));
        chk({tag, " flags"}, 64'({b0.out_overflow, b0.out_underflow, b0.out_inexact}),
            64'({v.ovf, v.uf0, v.inx}));
        chk({tag, " ftz1 result"}, 64'(b1.out_result), 64'(v.res1));
        chk({tag, " ftz1 flags"}, 64'({b1.out_overflow, b1.out_underflow, b1.out_inexact}),
            64'({v.ovf, v.uf1, v.inx}));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " held valid"}, 64'({b0.out_valid, b0.in_ready}), 64'b10);
            chk({tag, " held result"},
                {29'd0, b0.out_result, b0.out_overflow, b0.out_underflow, b0.out_inexact},
                {29'd0, v.res0, v.ovf, v.uf0, v.inx});
        end
        b0.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, " released"}, 64'({b0.out_valid, b0.in_ready}), 64'b01);
    endtask

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [63:0] rw;
        logic seen;
        int   sel;

        tbl[0]  = mk(0, 127, 33'h1_0000_0000, 0, 0, 0, 32'h40000000, 32'h40000000, 0, 0, 0, 0, 3);
        tbl[1]  = mk(0, 127, 33'h0_0000_0100, 0, 0, 0, 32'h34000000, 32'h34000000, 0, 0, 0, 0, 26);
        tbl[2]  = mk(0, 127, 33'h0_8000_0180, 0, 0, 0, 32'h3F800002, 32'h3F800002, 0, 0, 0, 1, 3);
        tbl[3]  = mk(0, 127, 33'h0_8000_0080, 0, 0, 0, 32'h3F800000, 32'h3F800000, 0, 0, 0, 1, 3);
        tbl[4]  = mk(0, 254, 33'h0_FFFF_FF80, 0, 0, 0, 32'h7F800000, 32'h7F800000, 1, 0, 0, 1, 3);
        tbl[5]  = mk(0, 1,   33'h0_4000_0000, 0, 0, 0, 32'h00400000, 32'h00000000, 0, 0, 1, 0, 3);
        tbl[6]  = mk(0, 1,   33'h0_4000_0080, 0, 0, 0, 32'h00400000, 32'h00000000, 0, 1, 1, 1, 3);
        tbl[7]  = mk(0, 9,   33'h0_0000_0000, 0, 1, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 50,  33'h0_0000_0000, 0, 0, 0, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 254, 33'h1_0000_0000, 0, 0, 0, 32'hFF800000, 32'hFF800000, 1, 0, 0, 1, 1);
        tbl[10] = mk(0, 100, 33'h0_0000_0000, 1, 0, 0, 32'h22800000, 32'h22800000, 0, 0, 0, 1, 34);
        tbl[11] = mk(0, 1,   33'h0_7FFF_FFC0, 0, 0, 0, 32'h00800000, 32'h00800000, 0, 0, 0, 1, 3);
        tbl[12] = mk(0, 127, 33'h0_8000_0080, 1, 0, 0, 32'h3F800001, 32'h3F800001, 0, 0, 0, 1, 3);

        reset = 1'b1;
        b0.in_valid = 1'b0; b0.in_sign = 1'b0; b0.in_exponent = 8'd0; b0.in_sum = 33'd0;
        b0.in_sticky = 1'b0; b0.in_bypass = 1'b0; b0.in_bypass_result = 32'd0; b0.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset state dut0",
            {29'd0, b0.in_ready, b0.out_valid, b0.out_result, b0.out_overflow, b0.out_underflow, b0.out_inexact},
            {29'd0, 1'b1, 1'b0, 32'd0, 3'b000});
        chk("reset state dut1",
            {29'd0, b1.in_ready, b1.out_valid, b1.out_result, b1.out_overflow, b1.out_underflow, b1.out_inexact},
            {29'd0, 1'b1, 1'b0, 32'd0, 3'b000});
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], 0, $sformatf("vec%0d", i));

        run_vec(tbl[0], 5, "backpressure");

        // Reset while shifting must discard the operation entirely.
        @(negedge clk);
        b0.in_valid = 1'b1; b0.in_sign = 1'b0; b0.in_exponent = 8'd127; b0.in_sum = 33'h0_0000_0100;
        b0.in_sticky = 1'b0; b0.in_bypass = 1'b0; b0.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b0.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset in norm", 64'({b0.out_valid, b0.in_ready, b1.out_valid, b1.in_ready}), 64'b0101);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (b0.out_valid || b1.out_valid) seen = 1'b1;
        end
        chk("no output after reset", 64'(seen), 64'd0);

        for (int i = 0; i < 150; i++) begin
            rw  = {$urandom, $urandom};
            sel = int'($urandom_range(0, 3));
            v.sign   = rw[63];
            v.ex     = (sel == 0) ? 8'($urandom_range(1, 30)) :
                       (sel == 1) ? 8'($urandom_range(240, 254)) : 8'($urandom_range(1, 254));
            v.sum    = rw[32:0] >> $urandom_range(0, 32);
            v.sticky = rw[40];
            v.bypass = ($urandom_range(0, 15) == 0);
            v.bres   = $urandom;
            if ($urandom_range(0, 19) == 0) v.sum = 33'd0;
            v = model(v.sign, v.ex, v.sum, v.sticky, v.bypass, v.bres);
            run_vec(v, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
